// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width, sequencer
// state encoding and the nibble-count helper used to size the index.
package sub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int unsigned nibble_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/subtractor_4bit.sv
// 4-bit ripple subtractor: diff = a - b - bin, bout set when a < b + bin.
module subtractor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic brw;

  always_comb begin
    diff = '0;
    brw  = bin;
    for (int unsigned i = 0; i < 4; i++) begin
      diff[i] = a[i] ^ b[i] ^ brw;
      brw     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
    end
    bout = brw;
  end

endmodule

// File: rtl/nibble_sub_sequencer.sv
// Sequences a WIDTH-bit subtraction through one subtractor_4bit, LSB nibble first.
// Optional SUB_OVF_EN adds a registered signed-overflow output (ovf).
module nibble_sub_sequencer
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NUM    = nibble_count(WIDTH);
  localparam int unsigned KW     = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NUM - 1);

  sub_state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             brw_q;
  logic [KW-1:0]    k_q;

  logic [NIBBLE_W-1:0] st_diff;
  logic                st_bout;

  // Operands shift right each RUN cycle, so nibble k always sits at bit 0;
  // in the last RUN cycle bit NIBBLE_W-1 of each is the operand MSB.
  subtractor_4bit u_stage (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .bin  (brw_q),
    .diff (st_diff),
    .bout (st_bout)
  );

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (k_q == LAST_K) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SUB_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      k_q     <= '0;
`ifdef SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          brw_q <= bin;
          k_q   <= '0;
          res_q <= '0;
        end
        RUN: begin
          a_q   <= a_q >> NIBBLE_W;
          b_q   <= b_q >> NIBBLE_W;
          res_q <= (res_q >> NIBBLE_W) | (WIDTH'(st_diff) << (WIDTH - NIBBLE_W));
          brw_q <= st_bout;
          k_q   <= k_q + 1'b1;
`ifdef SUB_OVF_EN
          if (k_q == LAST_K)
            ovf_q <= (a_q[NIBBLE_W-1] != b_q[NIBBLE_W-1]) &
                     (st_diff[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
`endif
        end
        default: ;
      endcase
    end
  end

  assign diff = res_q;
  assign bout = brw_q;

endmodule

// File: tb/tb_nibble_sub_sequencer.sv
// Directed self-checking bench for nibble_sub_sequencer (WIDTH=16).
module tb_nibble_sub_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [15:0] a, b;
  logic        busy, done, bout;
  logic [15:0] diff;
`ifdef SUB_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  nibble_sub_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds start for one cycle; returns just after the accepting edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    a = av; b = bv; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until done is seen, bounded at 20.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    checks++; if (diff !== 16'h0000) $display("FAIL reset_diff got=%h exp=0000", diff); else passed++;
    checks++; if (bout !== 1'b0) $display("FAIL reset_bout got=%b exp=0", bout); else passed++;
`ifdef SUB_OVF_EN
    checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
`endif
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_basic();
    int lat;
    start_op(16'h1234, 16'h0235, 1'b0);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_rise got=%b exp=1", busy); else passed++;
    wait_done(lat);
    checks++; if (lat != 4) $display("FAIL basic_latency got=%0d exp=4", lat); else passed++;
    checks++; if (diff !== 16'h0FFF) $display("FAIL basic_diff got=%h exp=0fff", diff); else passed++;
    checks++; if (bout !== 1'b0) $display("FAIL basic_bout got=%b exp=0", bout); else passed++;
`ifdef SUB_OVF_EN
    checks++; if (ovf !== 1'b0) $display("FAIL basic_ovf got=%b exp=0", ovf); else passed++;
`endif
    tick();
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_fall got=%b exp=0", busy); else passed++;
    tick();
    checks++; if (diff !== 16'h0FFF) $display("FAIL basic_diff_hold got=%h exp=0fff", diff); else passed++;
  endtask

  task automatic test_underflow();
    int lat;
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_done(lat);
    checks++; if (lat != 4) $display("FAIL uflow_latency got=%0d exp=4", lat); else passed++;
    checks++; if (diff !== 16'hFFFF) $display("FAIL uflow_diff got=%h exp=ffff", diff); else passed++;
    checks++; if (bout !== 1'b1) $display("FAIL uflow_bout got=%b exp=1", bout); else passed++;
`ifdef SUB_OVF_EN
    checks++; if (ovf !== 1'b0) $display("FAIL uflow_ovf got=%b exp=0", ovf); else passed++;
`endif
    tick();
  endtask

  task automatic test_borrow_in_ovf();
    int lat;
    start_op(16'h8000, 16'h0000, 1'b1);
    wait_done(lat);
    checks++; if (diff !== 16'h7FFF) $display("FAIL bin_diff got=%h exp=7fff", diff); else passed++;
    checks++; if (bout !== 1'b0) $display("FAIL bin_bout got=%b exp=0", bout); else passed++;
`ifdef SUB_OVF_EN
    checks++; if (ovf !== 1'b1) $display("FAIL bin_ovf got=%b exp=1", ovf); else passed++;
`endif
    tick();
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    start_op(16'h0005, 16'h0003, 1'b0);                 // now in cycle c+1
    tick();                                              // c+2
    a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    tick(); start = 1'b0; dones += int'(done);           // c+3
    tick(); dones += int'(done);                         // c+4
    tick(); dones += int'(done);                         // c+5 (DONE)
    checks++; if (done !== 1'b1) $display("FAIL ign_done_cycle got=%b exp=1", done); else passed++;
    checks++; if (diff !== 16'h0002) $display("FAIL ign_diff got=%h exp=0002", diff); else passed++;
    start = 1'b1;
    tick(); start = 1'b0; dones += int'(done);           // c+6
    checks++; if (busy !== 1'b0) $display("FAIL ign_busy_after got=%b exp=0", busy); else passed++;
    for (int i = 0; i < 6; i++) begin
      tick(); dones += int'(done);
    end
    checks++; if (dones != 1) $display("FAIL ign_done_count got=%0d exp=1", dones); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL ign_not_queued got=%b exp=0", busy); else passed++;
    checks++; if (diff !== 16'h0002) $display("FAIL ign_diff_hold got=%h exp=0002", diff); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int dones = 0;
    start_op(16'h1234, 16'h0235, 1'b0);                  // c+1
    tick();                                              // c+2
    rst = 1'b1;
    tick();                                              // c+3
    rst = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rmid_done got=%b exp=0", done); else passed++;
    checks++; if (diff !== 16'h0000) $display("FAIL rmid_diff got=%h exp=0000", diff); else passed++;
    checks++; if (bout !== 1'b0) $display("FAIL rmid_bout got=%b exp=0", bout); else passed++;
    for (int i = 0; i < 8; i++) begin
      tick(); dones += int'(done);
    end
    checks++; if (dones != 0) $display("FAIL rmid_no_done got=%0d exp=0", dones); else passed++;
    start_op(16'h1000, 16'h0001, 1'b0);
    wait_done(lat);
    checks++; if (lat != 4) $display("FAIL rmid_latency got=%0d exp=4", lat); else passed++;
    checks++; if (diff !== 16'h0FFF) $display("FAIL rmid_diff_new got=%h exp=0fff", diff); else passed++;
    checks++; if (bout !== 1'b0) $display("FAIL rmid_bout_new got=%b exp=0", bout); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(16'h00FF, 16'h0F00, 1'b0);
    wait_done(lat);                                      // DONE cycle
    checks++; if (diff !== 16'hF1FF) $display("FAIL b2b1_diff got=%h exp=f1ff", diff); else passed++;
    checks++; if (bout !== 1'b1) $display("FAIL b2b1_bout got=%b exp=1", bout); else passed++;
    tick();                                              // IDLE, 6 cycles after first start
    checks++; if (busy !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", busy); else passed++;
    start_op(16'hABCD, 16'hABCD, 1'b1);
    checks++; if (busy !== 1'b1) $display("FAIL b2b2_accept got=%b exp=1", busy); else passed++;
    wait_done(lat);
    checks++; if (lat != 4) $display("FAIL b2b2_latency got=%0d exp=4", lat); else passed++;
    checks++; if (diff !== 16'hFFFF) $display("FAIL b2b2_diff got=%h exp=ffff", diff); else passed++;
    checks++; if (bout !== 1'b1) $display("FAIL b2b2_bout got=%b exp=1", bout); else passed++;
`ifdef SUB_OVF_EN
    checks++; if (ovf !== 1'b0) $display("FAIL b2b2_ovf got=%b exp=0", ovf); else passed++;
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_borrow_in_ovf();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
